// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter among
// NREQ requesters. The winner's byte is latched and the transmitter sees a
// 4-phase tx_sent/tx_recieve handshake. A one-cycle ack is returned to the
// requester. A stuck transmitter is abandoned after TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic [DW-1:0]           tx_data,
  output logic                    tx_sent,
  input  logic                    tx_recieve,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t        state_reg;
  logic [GW-1:0] ptr_reg;
  logic [CW-1:0] cnt_reg;

  // Per-requester byte view of the packed data bus.
  logic [DW-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DW +: DW];
  end

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] probe_idx;

  // Pick the first active request after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      probe_idx = GW'((int'(ptr_reg) + k) % NREQ);
      if (!win_found && req[probe_idx]) begin
        win_found = 1'b1;
        win_idx   = probe_idx;
      end
    end
  end

  // Arbitration and handshake state machine; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= GW'(NREQ - 1);
      cnt_reg     <= '0;
      tx_sent     <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ack     <= '0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            tx_data   <= data_arr[win_idx];
            grant_id  <= win_idx;
            ptr_reg   <= win_idx;
            tx_sent   <= 1'b1;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // A tx_recieve still high from before counts as done at once.
          if (tx_recieve) begin
            tx_sent           <= 1'b0;
            req_ack[grant_id] <= 1'b1;
            state_reg         <= WAIT_LOW;
          end else if (cnt_reg == CNT_MAX) begin
            tx_sent     <= 1'b0;
            timeout_err <= 1'b1;
            state_reg   <= WAIT_LOW;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_LOW: begin
          // Wait for the transmitter to release before the next grant.
          if (!tx_recieve) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          tx_sent   <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: randomized requests and data
// checked against a round-robin reference model, plus the timing corners.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_sent;
  logic        tx_recieve = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int mdl_ptr = 3;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_ack(req_ack), .tx_data(tx_data), .tx_sent(tx_sent),
    .tx_recieve(tx_recieve), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: next winner is the first requester after the last one served.
  function automatic int model_pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      int i = (ptr + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req = '0;
    tx_recieve = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 3;
    tick();
  endtask

  task automatic wait_sent(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_sent === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Serve one grant: capture who/what was sent and the ack pulse shape.
  task automatic serve(input int delay, output bit ok, output int gid,
                       output logic [7:0] data, output logic [3:0] ack,
                       output int ack_w);
    wait_sent(ok);
    gid = -1; data = '0; ack = '0; ack_w = 0;
    if (!ok) return;
    gid  = int'(grant_id);
    data = tx_data;
    repeat (delay) tick();
    tx_recieve = 1'b1;
    tick();
    ack = req_ack;
    tx_recieve = 1'b0;
    tick();
    ack_w = (req_ack != 4'b0000) ? 2 : 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    tests++;
    if (tx_sent !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx_sent: got %b expected 0", tx_sent);
    end
    tests++;
    if ({tx_data, req_ack, grant_id, busy, timeout_err} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h ack=%b gid=%0d busy=%b te=%b expected all 0",
               tx_data, req_ack, grant_id, busy, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 3;
    tick();
    tick();
    tests++;
    if (busy !== 1'b0 || tx_sent !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: got busy=%b tx_sent=%b expected 0 0", busy, tx_sent);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int bad;
    tick();
    req_data = $urandom;
    req_data[7:0] = 8'h41;
    req = 4'b0001;
    tick();
    tests++;
    if (tx_sent !== 1'b1 || tx_data !== 8'h41 || grant_id !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: got sent=%b data=%h gid=%0d busy=%b expected 1 41 0 1",
               tx_sent, tx_data, grant_id, busy);
    end
    mdl_ptr = 0;
    bad = 0;
    repeat (10) begin
      tick();
      if (tx_sent !== 1'b1 || req_ack !== 4'b0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL single_hold: got %0d bad cycles expected 0", bad);
    end
    tx_recieve = 1'b1;
    tick();
    tests++;
    if (tx_sent !== 1'b0 || req_ack !== 4'b0001) begin
      fails++;
      $display("FAIL single_ack: got sent=%b ack=%b expected 0 0001", tx_sent, req_ack);
    end
    req = 4'b0000;
    tx_recieve = 1'b0;
    tick();
    tests++;
    if (req_ack !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_release: got ack=%b busy=%b expected 0000 0", req_ack, busy);
    end
    $display("[TB] single request 0x41 checked");
  endtask

  task automatic test_round_robin();
    bit ok; int gid; logic [7:0] d; logic [3:0] a; int w; int exp;
    logic [3:0] exp_ack;
    do_reset();
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    req = 4'b1111;
    for (int n = 0; n < 9; n++) begin
      exp = model_pick(req, mdl_ptr);
      exp_ack = 4'b0001 << exp;
      serve((n < 5) ? 2 : int'($urandom_range(0, 6)), ok, gid, d, a, w);
      tests++;
      if (!ok || gid != exp || d !== byte_of(req_data, exp) || a !== exp_ack || w != 1) begin
        fails++;
        $display("FAIL rr_grant%0d: got ok=%0d gid=%0d data=%h ack=%b width=%0d expected gid=%0d data=%h ack=%b width=1",
                 n, ok, gid, d, a, w, exp, byte_of(req_data, exp), exp_ack);
      end else begin
        $display("[TB] rr grant %0d -> requester %0d byte %h", n, gid, d);
      end
      mdl_ptr = exp;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    bit ok; int gid; logic [7:0] d; logic [3:0] a; int w; int exp;
    logic [3:0] exp_ack;
    for (int n = 0; n < 16; n++) begin
      req = 4'($urandom_range(1, 15));
      req_data = $urandom;
      exp = model_pick(req, mdl_ptr);
      exp_ack = 4'b0001 << exp;
      serve(int'($urandom_range(0, 5)), ok, gid, d, a, w);
      tests++;
      if (!ok || gid != exp || d !== byte_of(req_data, exp) || a !== exp_ack || w != 1) begin
        fails++;
        $display("FAIL rand%0d req=%b: got ok=%0d gid=%0d data=%h ack=%b width=%0d expected gid=%0d data=%h ack=%b width=1",
                 n, req, ok, gid, d, a, w, exp, byte_of(req_data, exp), exp_ack);
      end else begin
        $display("[TB] random req=%b -> requester %0d byte %h", req, gid, d);
      end
      mdl_ptr = exp;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    bit ok; int gid; logic [7:0] d; logic [3:0] a; int w;
    req_data = $urandom;
    req = 4'b1000;
    serve(1, ok, gid, d, a, w);
    tests++;
    if (!ok || gid != 3) begin
      fails++;
      $display("FAIL wrap_first: got ok=%0d gid=%0d expected 3", ok, gid);
    end
    mdl_ptr = 3;
    req = 4'b1001;
    serve(1, ok, gid, d, a, w);
    tests++;
    if (!ok || gid != 0 || d !== byte_of(req_data, 0)) begin
      fails++;
      $display("FAIL wrap_next: got ok=%0d gid=%0d data=%h expected 0 %h",
               ok, gid, d, byte_of(req_data, 0));
    end
    mdl_ptr = 0;
    req = 4'b0000;
    tick();
    $display("[TB] pointer wrap 3 -> 0 checked");
  endtask

  task automatic test_drop_req();
    bit ok; logic [7:0] exp_d;
    req_data = $urandom;
    req = 4'b0010;
    exp_d = byte_of(req_data, 1);
    wait_sent(ok);
    req = 4'b0000;
    req_data = ~req_data;
    repeat (3) tick();
    tests++;
    if (!ok || tx_data !== exp_d) begin
      fails++;
      $display("FAIL drop_data: got ok=%0d data=%h expected %h", ok, tx_data, exp_d);
    end
    tx_recieve = 1'b1;
    tick();
    tests++;
    if (req_ack !== 4'b0010) begin
      fails++;
      $display("FAIL drop_ack: got %b expected 0010", req_ack);
    end
    mdl_ptr = 1;
    tx_recieve = 1'b0;
    tick();
    $display("[TB] requester drop during send checked");
  endtask

  task automatic test_timeout();
    bit ok; int n; int pulses; int acks; bit te_drop; bit regrant; int gap;
    req_data = $urandom;
    req = 4'b0100;
    tx_recieve = 1'b0;
    wait_sent(ok);
    n = 1; pulses = 0; acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (timeout_err === 1'b1) pulses++;
      if (req_ack !== 4'b0000) acks++;
      if (tx_sent !== 1'b1) break;
      n++;
    end
    te_drop = timeout_err;
    regrant = 1'b0;
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      gap++;
      if (timeout_err === 1'b1) pulses++;
      if (req_ack !== 4'b0000) acks++;
      if (tx_sent === 1'b1) begin
        regrant = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok || n != TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout_len: got %0d cycles high expected %0d", n, TIMEOUT + 1);
    end
    tests++;
    if (te_drop !== 1'b1 || pulses != 1) begin
      fails++;
      $display("FAIL timeout_pulse: got at_drop=%b pulses=%0d expected 1 1", te_drop, pulses);
    end
    tests++;
    if (acks != 0) begin
      fails++;
      $display("FAIL timeout_ack: got %0d ack cycles expected 0", acks);
    end
    tests++;
    if (!regrant || gap != 2 || grant_id !== 2'd2 || tx_data !== byte_of(req_data, 2)) begin
      fails++;
      $display("FAIL timeout_regrant: got ok=%0d gap=%0d gid=%0d data=%h expected 1 2 2 %h",
               regrant, gap, grant_id, tx_data, byte_of(req_data, 2));
    end
    mdl_ptr = 2;
    tx_recieve = 1'b1;
    tick();
    req = 4'b0000;
    tx_recieve = 1'b0;
    tick();
    $display("[TB] timeout after %0d cycles checked", n);
  endtask

  task automatic test_guard();
    bit ok; int exp; int exp2; int bad;
    req_data = $urandom;
    req = 4'b0101;
    exp = model_pick(req, mdl_ptr);
    wait_sent(ok);
    tests++;
    if (!ok || int'(grant_id) != exp) begin
      fails++;
      $display("FAIL guard_first: got ok=%0d gid=%0d expected %0d", ok, grant_id, exp);
    end
    mdl_ptr = exp;
    tx_recieve = 1'b1;
    tick();
    req = req & ~(4'b0001 << exp);
    exp2 = model_pick(req, mdl_ptr);
    bad = 0;
    repeat (5) begin
      tick();
      if (tx_sent !== 1'b0) bad++;
    end
    tx_recieve = 1'b0;
    tick();
    if (tx_sent !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL guard_hold: got %0d cycles with tx_sent high expected 0", bad);
    end
    tick();
    tests++;
    if (tx_sent !== 1'b1 || int'(grant_id) != exp2 || tx_data !== byte_of(req_data, exp2)) begin
      fails++;
      $display("FAIL guard_next: got sent=%b gid=%0d data=%h expected 1 %0d %h",
               tx_sent, grant_id, tx_data, exp2, byte_of(req_data, exp2));
    end
    mdl_ptr = exp2;
    tx_recieve = 1'b1;
    tick();
    req = 4'b0000;
    tx_recieve = 1'b0;
    tick();
    $display("[TB] 4-phase guard checked");
  endtask

  task automatic test_async_reset();
    bit ok; int exp;
    req_data = $urandom;
    req = 4'b0001;
    wait_sent(ok);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (!ok || tx_sent !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got ok=%0d sent=%b busy=%b ack=%b te=%b expected 1 0 0 0000 0",
               ok, tx_sent, busy, req_ack, timeout_err);
    end
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 3;
    exp = model_pick(req, mdl_ptr);
    wait_sent(ok);
    tests++;
    if (!ok || int'(grant_id) != exp || grant_id !== 2'd2) begin
      fails++;
      $display("FAIL reset_regrant: got ok=%0d gid=%0d expected 2", ok, grant_id);
    end
    tx_recieve = 1'b1;
    tick();
    req = 4'b0000;
    tx_recieve = 1'b0;
    tick();
    $display("[TB] async reset mid-send checked");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_wrap();
    test_drop_req();
    test_timeout();
    test_guard();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
